// File: rtl/maxnet_plu_controller.sv
// maxnet_plu_controller: sequences four PLU lanes through Maxnet iterations
// (load, multiply, add, ReLU, convergence check) until one lane survives or the limit hits.
`default_nettype none

module maxnet_plu_controller #(
  parameter int DATA_W   = 32,
  parameter int MAX_ITER = 16,
  parameter int ITER_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] plu_out0,
  input  logic [DATA_W-1:0] plu_out1,
  input  logic [DATA_W-1:0] plu_out2,
  input  logic [DATA_W-1:0] plu_out3,
  output logic              w_we,
  output logic              a_we,
  output logic              a_sel,
  output logic              r1_we,
  output logic              r2_we,
  output logic              r3_we,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [1:0]        winner,
  output logic [ITER_W-1:0] iter_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FEED  = 3'd2,
    MUL   = 3'd3,
    ADD   = 3'd4,
    RELU  = 3'd5,
    CHECK = 3'd6,
    DONE  = 3'd7
  } state_t;

  state_t     state;
  state_t     nxt;
  logic [3:0] nz;
  logic [2:0] pop;
  logic [1:0] idx;
  logic       last_iter;

  always_comb begin
    nz  = {|plu_out3, |plu_out2, |plu_out1, |plu_out0};
    pop = {2'b00, nz[0]} + {2'b00, nz[1]} + {2'b00, nz[2]} + {2'b00, nz[3]};
    // Only meaningful when at most one lane is nonzero
    case (nz)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    last_iter = (iter_count + ITER_W'(1)) == ITER_W'(MAX_ITER);
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? LOAD : IDLE;
      LOAD:    nxt = MUL;
      FEED:    nxt = MUL;
      MUL:     nxt = ADD;
      ADD:     nxt = RELU;
      RELU:    nxt = CHECK;
      CHECK:   nxt = ((pop <= 3'd1) || last_iter) ? DONE : FEED;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      w_we       <= 1'b0;
      a_we       <= 1'b0;
      a_sel      <= 1'b0;
      r1_we      <= 1'b0;
      r2_we      <= 1'b0;
      r3_we      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      converged  <= 1'b0;
      winner     <= 2'd0;
      iter_count <= '0;
    end else begin
      state <= nxt;
      w_we  <= (nxt == LOAD);
      a_we  <= (nxt == LOAD) || (nxt == FEED);
      a_sel <= (nxt == LOAD);
      r1_we <= (nxt == MUL);
      r2_we <= (nxt == ADD);
      r3_we <= (nxt == RELU);
      busy  <= (nxt != IDLE);
      done  <= (nxt == DONE);

      if (state == IDLE && start) begin
        iter_count <= '0;
        converged  <= 1'b0;
        winner     <= 2'd0;
      end else if (state == CHECK) begin
        iter_count <= iter_count + ITER_W'(1);
        if (pop <= 3'd1) begin
          converged <= 1'b1;
          winner    <= idx;
        end else if (last_iter) begin
          converged <= 1'b0;
          winner    <= 2'd0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_maxnet_plu_controller.sv
// Bench for maxnet_plu_controller: directed scenarios plus random competitions
// checked against a cycle-schedule model derived from the iteration rules.
`default_nettype none

module tb_maxnet_plu_controller;
  localparam int DW = 32;
  localparam int MI = 4;
  localparam int IW = 5;

  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_FEED  = 2;
  localparam int P_MUL   = 3;
  localparam int P_ADD   = 4;
  localparam int P_RELU  = 5;
  localparam int P_CHECK = 6;
  localparam int P_DONE  = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] p0, p1, p2, p3;
  logic          w_we, a_we, a_sel, r1_we, r2_we, r3_we, busy, done, converged;
  logic [1:0]    winner;
  logic [IW-1:0] iter_count;

  int total  = 0;
  int passed = 0;
  logic [31:0] vec [0:MI-1][0:3];

  maxnet_plu_controller #(.DATA_W(DW), .MAX_ITER(MI), .ITER_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .plu_out0(p0), .plu_out1(p1), .plu_out2(p2), .plu_out3(p3),
    .w_we(w_we), .a_we(a_we), .a_sel(a_sel), .r1_we(r1_we), .r2_we(r2_we), .r3_we(r3_we),
    .busy(busy), .done(done), .converged(converged), .winner(winner), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // {w_we,a_we,a_sel,r1_we,r2_we,r3_we,busy,done} expected for each phase of the schedule
  function automatic logic [7:0] phase_out(input int ph);
    case (ph)
      P_LOAD:  return 8'b1110_0010;
      P_FEED:  return 8'b0100_0010;
      P_MUL:   return 8'b0001_0010;
      P_ADD:   return 8'b0000_1010;
      P_RELU:  return 8'b0000_0110;
      P_CHECK: return 8'b0000_0010;
      P_DONE:  return 8'b0000_0011;
      default: return 8'b0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] outs();
    return {24'd0, w_we, a_we, a_sel, r1_we, r2_we, r3_we, busy, done};
  endfunction

  task automatic drive_rand();
    p0 = $urandom; p1 = $urandom; p2 = $urandom; p3 = $urandom;
  endtask

  // Full competition: model predicts iterations/result, then every cycle is checked
  task automatic run_comp(input string tag, input bit noise);
    int iters, win, t, ph, k, j, cnt;
    bit conv;
    iters = MI; conv = 1'b0; win = 0;
    for (int i = 0; i < MI; i++) begin
      cnt = 0;
      for (int l = 0; l < 4; l++) if (vec[i][l] != 0) begin cnt++; win = l; end
      if (cnt <= 1) begin
        iters = i + 1; conv = 1'b1;
        if (cnt == 0) win = 0;
        break;
      end
    end
    if (!conv) win = 0;
    t = 6 + 5 * (iters - 1);
    @(negedge clk);
    start = 1'b1;
    drive_rand();
    for (int c = 1; c <= t + 2; c++) begin
      @(negedge clk);
      k = 0; j = 0;
      if (c > t)       ph = P_IDLE;
      else if (c == 1) ph = P_LOAD;
      else if (c == t) ph = P_DONE;
      else begin
        j = (c - 2) % 5; k = (c - 2) / 5;
        ph = (j == 0) ? P_MUL : (j == 1) ? P_ADD : (j == 2) ? P_RELU : (j == 3) ? P_CHECK : P_FEED;
      end
      chk($sformatf("%s_c%0d_outs", tag, c), outs(), {24'd0, phase_out(ph)});
      if (ph == P_DONE || c == t + 2) begin
        chk({tag, "_converged"}, {31'd0, converged}, {31'd0, conv});
        chk({tag, "_winner"}, {30'd0, winner}, win);
        chk({tag, "_iter"}, {27'd0, iter_count}, iters);
      end
      start = noise && (ph == P_MUL || ph == P_CHECK || ph == P_DONE);
      if (ph == P_CHECK) begin
        p0 = vec[k][0]; p1 = vec[k][1]; p2 = vec[k][2]; p3 = vec[k][3];
      end else drive_rand();
    end
    start = 1'b0;
  endtask

  task automatic set_all(input logic [31:0] l0, l1, l2, l3);
    for (int i = 0; i < MI; i++) begin
      vec[i][0] = l0; vec[i][1] = l1; vec[i][2] = l2; vec[i][3] = l3;
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_outs"}, outs(), 32'd0);
    chk({tag, "_res"}, {28'd0, converged, winner, 1'b0}, 32'd0);
    chk({tag, "_iter"}, {27'd0, iter_count}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; p0 = '0; p1 = '0; p2 = '0; p3 = '0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // T2: single iteration, lane 2 wins
    set_all(0, 0, 0, 0); vec[0][2] = 5;
    run_comp("t2", 1'b0);

    // T3: two contested iterations, then lane 1 alone
    set_all(0, 4, 0, 0);
    vec[0][0] = 3; vec[0][1] = 7; vec[1][0] = 3; vec[1][1] = 7;
    run_comp("t3", 1'b0);

    // T4: never converges, hits iteration limit
    set_all(1, 1, 1, 1);
    run_comp("t4", 1'b0);

    // T5: all zero, with start pulses mid-run that must be ignored
    set_all(0, 0, 0, 0);
    run_comp("t5", 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("t5_no_restart", outs(), 32'd0);
    end

    // T1: async reset mid-cycle during a run
    set_all(2, 2, 0, 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("t1_busy_before", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_state("t1_async");
    @(negedge clk); rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("t1_idle_after", outs(), 32'd0);
    end

    // T6: reset during ADD of iteration 2, then a fresh run
    @(negedge clk); start = 1'b1; drive_rand();
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 5) begin p0 = 9; p1 = 9; p2 = 0; p3 = 0; end else drive_rand();
    end
    chk("t6_in_add", outs(), {24'd0, phase_out(P_ADD)});
    chk("t6_iter_mid", {27'd0, iter_count}, 32'd1);
    rst = 1'b1;
    #1 check_reset_state("t6_abort");
    @(negedge clk); rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("t6_no_done", {31'd0, done}, 32'd0);
    end
    set_all(0, 0, 0, 0); vec[0][3] = 32'h8000_0000;
    run_comp("t6_rerun", 1'b0);

    // Random competitions
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < MI; i++)
        for (int l = 0; l < 4; l++)
          vec[i][l] = ($urandom_range(0, 1) == 0) ? 32'd0 :
                      ($urandom_range(0, 1) == 0) ? (32'd1 << $urandom_range(0, 31)) : ($urandom | 32'd1);
      run_comp($sformatf("rand%0d", r), r[0]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
